// File: rtl/hilo_unit_if.sv
// -----------------------------------------------------------------------------
// hilo_unit_if
// Op request / register readback bundle between the writeback stage and the
// HI/LO special-register unit.
//   master modport : writeback stage (issues ops, reads HI/LO)
//   slave modport  : hilo_unit
// Signals:
//   op_valid       op request
//   op_ready       unit can accept an op
//   op_mode        0 WR_HILO, 1 WR_HI, 2 WR_LO, 3 MADD, 4 MSUB, 5-7 reserved
//   write_hi_data  HI write data / addend upper half
//   write_lo_data  LO write data / addend lower half
//   hi_data        HI register value
//   lo_data        LO register value
//   busy           accumulate in progress
//   acc_done       one-cycle pulse when an accumulate finishes
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface hilo_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  op_valid;
  logic                  op_ready;
  logic [2:0]            op_mode;
  logic [DATA_WIDTH-1:0] write_hi_data;
  logic [DATA_WIDTH-1:0] write_lo_data;
  logic [DATA_WIDTH-1:0] hi_data;
  logic [DATA_WIDTH-1:0] lo_data;
  logic                  busy;
  logic                  acc_done;

  modport master (
    output op_valid, op_mode, write_hi_data, write_lo_data,
    input  op_ready, hi_data, lo_data, busy, acc_done
  );

  modport slave (
    input  op_valid, op_mode, write_hi_data, write_lo_data,
    output op_ready, hi_data, lo_data, busy, acc_done
  );
endinterface

// File: rtl/hilo_unit.sv
// -----------------------------------------------------------------------------
// hilo_unit
// HI/LO special-register pair with full/half writes and a two-step
// 2*DATA_WIDTH multiply-accumulate update (MADD adds, MSUB subtracts the
// {write_hi_data, write_lo_data} addend). LO half is updated first, its
// carry/borrow is kept in a 1-bit register and folded into the HI half on
// the following cycle.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-high reset, clears all state
//   bus    hilo_unit_if.slave (op handshake, write data, HI/LO readback,
//          busy, acc_done)
// Configuration:
//   HILO_BYPASS_EN  when defined, a WR_* op accepted this cycle is forwarded
//                   combinationally to hi_data/lo_data; otherwise hi_data and
//                   lo_data are plain register outputs.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module hilo_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic        clock,
  input  logic        reset,
  hilo_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_LO = 2'd1,
    ACC_HI = 2'd2
  } state_t;

  localparam logic [2:0] MODE_WR_HILO = 3'd0;
  localparam logic [2:0] MODE_WR_HI   = 3'd1;
  localparam logic [2:0] MODE_WR_LO   = 3'd2;
  localparam logic [2:0] MODE_MADD    = 3'd3;
  localparam logic [2:0] MODE_MSUB    = 3'd4;

  state_t                state_r;
  state_t                state_s;
  logic                  op_ready_r;
  logic                  acc_done_r;
  logic [DATA_WIDTH-1:0] hi_r;
  logic [DATA_WIDTH-1:0] lo_r;
  logic [DATA_WIDTH-1:0] addend_hi_r;
  logic [DATA_WIDTH-1:0] addend_lo_r;
  logic                  sub_r;     // latched op is MSUB
  logic                  carry_r;   // carry (MADD) or borrow (MSUB) from LO half

  logic                  accept_s;
  logic                  wr_hi_en_s;
  logic                  wr_lo_en_s;
  logic                  acc_start_s;
  logic                  acc_lo_en_s;
  logic                  acc_hi_en_s;
  logic [DATA_WIDTH:0]   lo_sum_s;  // MSB is carry-out / borrow-out
  logic [DATA_WIDTH-1:0] hi_sum_s;
  logic [DATA_WIDTH-1:0] carry_ext_s;

  assign accept_s = bus.op_valid & op_ready_r;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and per-cycle update enables
  always_comb begin
    state_s     = state_r;
    wr_hi_en_s  = 1'b0;
    wr_lo_en_s  = 1'b0;
    acc_start_s = 1'b0;
    acc_lo_en_s = 1'b0;
    acc_hi_en_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          case (bus.op_mode)
            MODE_WR_HILO: begin
              wr_hi_en_s = 1'b1;
              wr_lo_en_s = 1'b1;
            end
            MODE_WR_HI: wr_hi_en_s = 1'b1;
            MODE_WR_LO: wr_lo_en_s = 1'b1;
            MODE_MADD, MODE_MSUB: begin
              acc_start_s = 1'b1;
              state_s     = ACC_LO;
            end
            // reserved modes are accepted and do nothing
            default: state_s = IDLE;
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      ACC_LO: begin
        acc_lo_en_s = 1'b1;
        state_s     = ACC_HI;
      end
      ACC_HI: begin
        acc_hi_en_s = 1'b1;
        state_s     = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Half-width add/subtract; the extra LO bit captures carry or borrow
  always_comb begin
    carry_ext_s = {{(DATA_WIDTH-1){1'b0}}, carry_r};
    if (sub_r) begin
      lo_sum_s = {1'b0, lo_r} - {1'b0, addend_lo_r};
      hi_sum_s = hi_r - addend_hi_r - carry_ext_s;
    end else begin
      lo_sum_s = {1'b0, lo_r} + {1'b0, addend_lo_r};
      hi_sum_s = hi_r + addend_hi_r + carry_ext_s;
    end
  end

  // Handshake and completion flags, aligned with the state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_ready_r <= 1'b1;
      acc_done_r <= 1'b0;
    end else begin
      op_ready_r <= (state_s == IDLE);
      acc_done_r <= acc_hi_en_s;
    end
  end

  // HI/LO registers, addend latch and carry flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi_r        <= {DATA_WIDTH{1'b0}};
      lo_r        <= {DATA_WIDTH{1'b0}};
      addend_hi_r <= {DATA_WIDTH{1'b0}};
      addend_lo_r <= {DATA_WIDTH{1'b0}};
      sub_r       <= 1'b0;
      carry_r     <= 1'b0;
    end else begin
      if (wr_hi_en_s) begin
        hi_r <= bus.write_hi_data;
      end else if (acc_hi_en_s) begin
        hi_r <= hi_sum_s;
      end
      if (wr_lo_en_s) begin
        lo_r <= bus.write_lo_data;
      end else if (acc_lo_en_s) begin
        lo_r    <= lo_sum_s[DATA_WIDTH-1:0];
        carry_r <= lo_sum_s[DATA_WIDTH];
      end
      if (acc_start_s) begin
        addend_hi_r <= bus.write_hi_data;
        addend_lo_r <= bus.write_lo_data;
        sub_r       <= (bus.op_mode == MODE_MSUB);
      end
    end
  end

  assign bus.op_ready = op_ready_r;
  assign bus.busy     = ~op_ready_r;
  assign bus.acc_done = acc_done_r;

`ifdef HILO_BYPASS_EN
  logic [DATA_WIDTH-1:0] hi_out_s;
  logic [DATA_WIDTH-1:0] lo_out_s;

  // Forward write data of an op accepted this cycle; accumulates are not
  // forwarded because busy already stalls readers
  always_comb begin
    hi_out_s = hi_r;
    lo_out_s = lo_r;
    if (wr_hi_en_s) begin
      hi_out_s = bus.write_hi_data;
    end else begin
      hi_out_s = hi_r;
    end
    if (wr_lo_en_s) begin
      lo_out_s = bus.write_lo_data;
    end else begin
      lo_out_s = lo_r;
    end
  end

  assign bus.hi_data = hi_out_s;
  assign bus.lo_data = lo_out_s;
`else
  assign bus.hi_data = hi_r;
  assign bus.lo_data = lo_r;
`endif

endmodule

// File: tb/tb_hilo_unit.sv
`timescale 1ns/1ps
module tb_hilo_unit;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  hilo_unit_if #(.DATA_WIDTH(32)) bus ();

  hilo_unit #(.DATA_WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  mode;
    logic [31:0] whi;
    logic [31:0] wlo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // one-cycle op: drive on negedge, release just after the accept edge
  task automatic do_op(input logic [2:0] mode, input logic [31:0] whi, input logic [31:0] wlo);
    @(negedge clock);
    bus.op_valid      = 1'b1;
    bus.op_mode       = mode;
    bus.write_hi_data = whi;
    bus.write_lo_data = wlo;
    @(posedge clock);
    #1;
    bus.op_valid = 1'b0;
  endtask

  // full accumulate: accept edge, ACC_LO edge, ACC_HI edge, pulse checks
  task automatic run_acc(input string name, input logic [2:0] mode,
                         input logic [31:0] ahi, input logic [31:0] alo,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    do_op(mode, ahi, alo);
    chk({name, "_ready_low0"}, {31'd0, bus.op_ready}, 32'd0);
    chk({name, "_busy0"}, {31'd0, bus.busy}, 32'd1);
    @(posedge clock); #1;
    chk({name, "_lo_mid"}, bus.lo_data, exp_lo);
    chk({name, "_ready_low1"}, {31'd0, bus.op_ready}, 32'd0);
    @(posedge clock); #1;
    chk({name, "_hi"}, bus.hi_data, exp_hi);
    chk({name, "_lo"}, bus.lo_data, exp_lo);
    chk({name, "_done"}, {31'd0, bus.acc_done}, 32'd1);
    chk({name, "_ready"}, {31'd0, bus.op_ready}, 32'd1);
    @(posedge clock); #1;
    chk({name, "_done_pulse"}, {31'd0, bus.acc_done}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{3'd0, 32'h12345678, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0};
    vecs[1] = '{3'd1, 32'hFFFFFFFF, 32'h11111111, 32'hFFFFFFFF, 32'h9ABCDEF0};
    vecs[2] = '{3'd6, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h9ABCDEF0};
    vecs[3] = '{3'd2, 32'h22222222, 32'h00000005, 32'hFFFFFFFF, 32'h00000005};
    vecs[4] = '{3'd5, 32'h33333333, 32'h44444444, 32'hFFFFFFFF, 32'h00000005};
    vecs[5] = '{3'd7, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 32'h00000005};
    vecs[6] = '{3'd0, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[7] = '{3'd2, 32'h77777777, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF};

    bus.op_valid      = 1'b0;
    bus.op_mode       = 3'd0;
    bus.write_hi_data = 32'd0;
    bus.write_lo_data = 32'd0;
    reset             = 1'b1;
    #2;
    chk("reset_hi", bus.hi_data, 32'd0);
    chk("reset_lo", bus.lo_data, 32'd0);
    chk("reset_ready", {31'd0, bus.op_ready}, 32'd1);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.acc_done}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // async reset mid-cycle with no clock edge
    do_op(3'd0, 32'hCAFEF00D, 32'h0BADC0DE);
    chk("pre_async_hi", bus.hi_data, 32'hCAFEF00D);
    #2;
    reset = 1'b1;
    #1;
    chk("async_hi", bus.hi_data, 32'd0);
    chk("async_lo", bus.lo_data, 32'd0);
    chk("async_ready", {31'd0, bus.op_ready}, 32'd1);
    chk("async_busy", {31'd0, bus.busy}, 32'd0);
    chk("async_done", {31'd0, bus.acc_done}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // single-cycle writes and reserved modes
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].mode, vecs[i].whi, vecs[i].wlo);
      chk($sformatf("vec%0d_hi", i), bus.hi_data, vecs[i].exp_hi);
      chk($sformatf("vec%0d_lo", i), bus.lo_data, vecs[i].exp_lo);
      chk($sformatf("vec%0d_ready", i), {31'd0, bus.op_ready}, 32'd1);
      chk($sformatf("vec%0d_done", i), {31'd0, bus.acc_done}, 32'd0);
    end

    // MADD carry from LO into HI
    do_op(3'd0, 32'h00000001, 32'hFFFFFFFF);
    run_acc("madd_carry", 3'd3, 32'h00000000, 32'h00000001, 32'h00000002, 32'h00000000);

    // MSUB borrow, then full wrap below zero
    do_op(3'd0, 32'h00000001, 32'h00000000);
    run_acc("msub_borrow", 3'd4, 32'h00000000, 32'h00000001, 32'h00000000, 32'hFFFFFFFF);
    do_op(3'd0, 32'h00000000, 32'h00000000);
    run_acc("msub_wrap", 3'd4, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF);

    // MADD overflow wraps silently, addend with both halves
    do_op(3'd0, 32'hFFFFFFFF, 32'h80000000);
    run_acc("madd_wrap", 3'd3, 32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000);

    // write offered while busy is ignored
    do_op(3'd0, 32'h00000000, 32'h00000010);
    do_op(3'd3, 32'h00000000, 32'h00000020);
    @(negedge clock);
    bus.op_valid      = 1'b1;
    bus.op_mode       = 3'd2;
    bus.write_lo_data = 32'h00000005;
    @(posedge clock); #1;
    chk("busy_wr_lo_mid", bus.lo_data, 32'h00000030);
    @(posedge clock); #1;
    bus.op_valid = 1'b0;
    chk("busy_wr_lo_end", bus.lo_data, 32'h00000030);
    chk("busy_wr_done", {31'd0, bus.acc_done}, 32'd1);
    @(posedge clock); #1;
    chk("busy_wr_lo_after", bus.lo_data, 32'h00000030);
    chk("busy_wr_hi_after", bus.hi_data, 32'h00000000);

    // reset while in ACC_HI aborts the accumulate
    do_op(3'd0, 32'h00000004, 32'h00000004);
    do_op(3'd3, 32'h00000001, 32'h00000001);
    @(posedge clock); #1;
    chk("abort_lo_mid", bus.lo_data, 32'h00000005);
    chk("abort_hi_mid", bus.hi_data, 32'h00000004);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort_hi", bus.hi_data, 32'd0);
    chk("abort_lo", bus.lo_data, 32'd0);
    chk("abort_ready", {31'd0, bus.op_ready}, 32'd1);
    chk("abort_done", {31'd0, bus.acc_done}, 32'd0);
    @(posedge clock); #1;
    chk("abort_done_edge", {31'd0, bus.acc_done}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("abort_done_after", {31'd0, bus.acc_done}, 32'd0);
    chk("abort_ready_after", {31'd0, bus.op_ready}, 32'd1);

    // write visibility in the accept cycle
    @(negedge clock);
    bus.op_valid      = 1'b1;
    bus.op_mode       = 3'd0;
    bus.write_hi_data = 32'h0000000A;
    bus.write_lo_data = 32'h0000000B;
    #1;
`ifdef HILO_BYPASS_EN
    chk("bypass_hi_same", bus.hi_data, 32'h0000000A);
    chk("bypass_lo_same", bus.lo_data, 32'h0000000B);
`else
    chk("nobypass_hi_same", bus.hi_data, 32'h00000000);
    chk("nobypass_lo_same", bus.lo_data, 32'h00000000);
`endif
    @(posedge clock); #1;
    bus.op_valid = 1'b0;
    chk("write_hi_next", bus.hi_data, 32'h0000000A);
    chk("write_lo_next", bus.lo_data, 32'h0000000B);

    // back-to-back MADD accepted in the acc_done cycle
    do_op(3'd3, 32'h00000001, 32'h00000001);
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("b2b_done1", {31'd0, bus.acc_done}, 32'd1);
    bus.op_valid = 1'b1;
    bus.op_mode  = 3'd3;
    @(posedge clock); #1;
    bus.op_valid = 1'b0;
    chk("b2b_accept", {31'd0, bus.busy}, 32'd1);
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("b2b_done2", {31'd0, bus.acc_done}, 32'd1);
    chk("b2b_hi", bus.hi_data, 32'h0000000C);
    chk("b2b_lo", bus.lo_data, 32'h0000000D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
